// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the FSM state encoding, the reset PC, the NOP word and the PC step.
package if_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;

    // Word-align a fetch target by clearing bits [1:0].
    function automatic logic [31:0] align_pc(input logic [31:0] a);
        return a & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request bus used by the fetch stage.
// Handshake: req/addr are held stable from assertion until the cycle ack=1; ack may coincide with the first req cycle.
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over the imem bus and holds the word until IF/ID accepts it.
// Redirects always win; a request already on the bus is drained and its data dropped.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP      = NOP_WORD
) (
    input  logic                clk,
    input  logic                reset,
    if_fetch_unit_if.master     imem,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    input  logic                IF_ID_En,
    output logic                valid,
    output logic [31:0]         IR_Out,
    output logic [31:0]         PC_Out_Out,
    output fetch_state_t        state
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  ir_q;
    logic [31:0]  tgt_q;
    logic         valid_q;

    // Request is a pure function of the state register, so it is glitch-free and stable until ack.
    assign imem.imem_req  = reset && (state_q != HOLD);
    assign imem.imem_addr = pc_q;

    assign valid      = reset && (state_q == HOLD) && valid_q && !redirect;
    assign IR_Out     = valid ? ir_q : NOP;
    assign PC_Out_Out = pc_q;
    assign state      = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            tgt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem.imem_ack) begin
                        if (redirect) begin
                            pc_q    <= align_pc(redirect_pc);
                            state_q <= FETCH;
                        end else begin
                            ir_q    <= imem.imem_rdata;
                            valid_q <= 1'b1;
                            state_q <= HOLD;
                        end
                    end else if (redirect) begin
                        tgt_q   <= align_pc(redirect_pc);
                        state_q <= DRAIN;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        valid_q <= 1'b0;
                        pc_q    <= align_pc(redirect_pc);
                        state_q <= FETCH;
                    end else if (IF_ID_En) begin
                        valid_q <= 1'b0;
                        pc_q    <= pc_q + PC_STEP;
                        state_q <= FETCH;
                    end
                end
                DRAIN: begin
                    if (redirect) begin
                        tgt_q <= align_pc(redirect_pc);
                    end
                    if (imem.imem_ack) begin
                        pc_q    <= redirect ? align_pc(redirect_pc) : tgt_q;
                        state_q <= FETCH;
                    end
                end
                default: begin
                    state_q <= FETCH;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios, then random redirects/stalls/memory latency
// checked against an accepted-instruction-stream model.
module tb_if_fetch_unit;
    import if_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         redirect = 1'b0;
    logic [31:0]  redirect_pc = '0;
    logic         IF_ID_En = 1'b0;
    logic         valid;
    logic [31:0]  IR_Out;
    logic [31:0]  PC_Out_Out;
    fetch_state_t st;

    int n_assert = 0;
    int n_fail   = 0;

    if_fetch_unit_if bus ();

    if_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (bus),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .IF_ID_En    (IF_ID_En),
        .valid       (valid),
        .IR_Out      (IR_Out),
        .PC_Out_Out  (PC_Out_Out),
        .state       (st)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic rd, input logic [31:0] rpc, input logic en,
                         input logic ak, input logic [31:0] data);
        @(negedge clk);
        redirect       = rd;
        redirect_pc    = rpc;
        IF_ID_En       = en;
        bus.imem_ack   = ak;
        bus.imem_rdata = data;
        #1;
    endtask

    logic [31:0] exp_next;
    logic [31:0] lat_addr;
    logic        busy;
    int          wt;
    int          accepts;

    initial begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        repeat (2) @(posedge clk);

        drive(0, 0, 0, 0, 0);
        check("rst_req",   {31'b0, bus.imem_req}, 32'd0);
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_ir",    IR_Out, NOP_WORD);
        check("rst_pc",    PC_Out_Out, 32'h0000_3000);
        check("rst_state", 32'(st), 32'(FETCH));
        reset = 1'b1;

        drive(0, 0, 1, 1, 32'h3C01_0001);
        check("c1_req",   {31'b0, bus.imem_req}, 32'd1);
        check("c1_addr",  bus.imem_addr, 32'h0000_3000);
        check("c1_valid", {31'b0, valid}, 32'd0);
        drive(0, 0, 1, 0, 0);
        check("c2_valid", {31'b0, valid}, 32'd1);
        check("c2_ir",    IR_Out, 32'h3C01_0001);
        check("c2_pc",    PC_Out_Out, 32'h0000_3000);
        check("c2_req",   {31'b0, bus.imem_req}, 32'd0);
        drive(0, 0, 0, 1, 32'h1111_1111);
        check("c3_req",   {31'b0, bus.imem_req}, 32'd1);
        check("c3_addr",  bus.imem_addr, 32'h0000_3004);

        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0);
            check("stall_valid", {31'b0, valid}, 32'd1);
            check("stall_ir",    IR_Out, 32'h1111_1111);
            check("stall_pc",    PC_Out_Out, 32'h0000_3004);
            check("stall_req",   {31'b0, bus.imem_req}, 32'd0);
        end
        drive(0, 0, 1, 0, 0);
        check("xfer_valid", {31'b0, valid}, 32'd1);

        drive(0, 0, 0, 0, 0);
        check("w0_addr", bus.imem_addr, 32'h0000_3008);
        drive(1, 32'h0000_3100, 0, 0, 0);
        check("w1_addr",  bus.imem_addr, 32'h0000_3008);
        check("w1_valid", {31'b0, valid}, 32'd0);
        drive(0, 0, 0, 0, 0);
        check("w2_state", 32'(st), 32'(DRAIN));
        check("w2_addr",  bus.imem_addr, 32'h0000_3008);
        check("w2_req",   {31'b0, bus.imem_req}, 32'd1);
        drive(0, 0, 0, 1, 32'hDEAD_DEAD);
        check("w3_addr",  bus.imem_addr, 32'h0000_3008);
        check("w3_valid", {31'b0, valid}, 32'd0);
        drive(0, 0, 0, 1, 32'h0085_1020);
        check("rd_addr",  bus.imem_addr, 32'h0000_3100);
        check("rd_state", 32'(st), 32'(FETCH));

        drive(1, 32'h0000_3200, 1, 0, 0);
        check("col_valid", {31'b0, valid}, 32'd0);
        check("col_ir",    IR_Out, NOP_WORD);
        check("col_pc",    PC_Out_Out, 32'h0000_3100);
        drive(1, 32'hFFFF_FFFE, 0, 0, 0);
        check("col_next", bus.imem_addr, 32'h0000_3200);
        drive(0, 0, 0, 1, 0);
        check("mis_state", 32'(st), 32'(DRAIN));
        check("mis_addr",  bus.imem_addr, 32'h0000_3200);
        drive(0, 0, 0, 1, 32'hCAFE_F00D);
        check("mis_aligned", bus.imem_addr, 32'hFFFF_FFFC);
        drive(0, 0, 1, 0, 0);
        check("top_valid", {31'b0, valid}, 32'd1);
        check("top_ir",    IR_Out, 32'hCAFE_F00D);
        check("top_pc",    PC_Out_Out, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0, 0);
        check("wrap_addr", bus.imem_addr, 32'h0000_0000);

        drive(1, 32'h0000_4000, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        check("mrst_state_pre", 32'(st), 32'(DRAIN));
        reset = 1'b0;
        #1;
        check("mrst_req",   {31'b0, bus.imem_req}, 32'd0);
        check("mrst_valid", {31'b0, valid}, 32'd0);
        check("mrst_pc",    PC_Out_Out, 32'h0000_3000);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        check("mrst_restart", bus.imem_addr, 32'h0000_3000);
        check("mrst_rreq",    {31'b0, bus.imem_req}, 32'd1);
        check("mrst_state",   32'(st), 32'(FETCH));

        // Random phase: model tracks only the program-order PC the next accepted instruction must carry.
        drive(0, 0, 0, 0, 0);
        reset    = 1'b0;
        #1;
        reset    = 1'b1;
        exp_next = 32'h0000_3000;
        busy     = 1'b0;
        wt       = 0;
        lat_addr = '0;
        accepts  = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            redirect    = ($urandom_range(0, 7) == 0);
            redirect_pc = $urandom();
            IF_ID_En    = $urandom_range(0, 1) == 1;
            if (bus.imem_req) begin
                if (!busy) begin
                    busy     = 1'b1;
                    lat_addr = bus.imem_addr;
                    wt       = $urandom_range(0, 3);
                end else begin
                    check("rnd_addr_stable", bus.imem_addr, lat_addr);
                end
                check("rnd_addr_align", {30'b0, bus.imem_addr[1:0]}, 32'd0);
                bus.imem_ack   = (wt == 0);
                bus.imem_rdata = (wt == 0) ? mem_word(lat_addr) : $urandom();
                if (wt == 0) busy = 1'b0;
                else wt--;
            end else begin
                bus.imem_ack   = 1'b0;
                bus.imem_rdata = $urandom();
                busy           = 1'b0;
            end
            #1;
            if (!valid) begin
                check("rnd_nop", IR_Out, NOP_WORD);
            end else if (IF_ID_En) begin
                check("rnd_acc_pc", PC_Out_Out, exp_next);
                check("rnd_acc_ir", IR_Out, mem_word(exp_next));
                exp_next = exp_next + 32'd4;
                accepts++;
            end
            if (redirect) exp_next = redirect_pc & 32'hFFFF_FFFC;
        end
        @(negedge clk);
        redirect     = 1'b0;
        IF_ID_En     = 1'b0;
        bus.imem_ack = 1'b0;
        check("rnd_progress", {31'b0, accepts >= 50}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
